// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and parity-mode constants shared by the UART transmit and receive paths
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_DONE
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

endpackage

// File: rtl/baud_counter.sv
// baud_counter: free-running 0..CLKS_PER_BIT-1 bit-period counter
//   clk, reset (async, active-high); clear restarts the count at 0;
//   tick is high while the count sits at its terminal value.
module baud_counter #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int W = $clog2(CLKS_PER_BIT);
    localparam logic [W-1:0] TERM = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] cnt;

    assign tick = cnt == TERM;

    always_ff @(posedge clk or posedge reset)
        if (reset) cnt <= '0;
        else       cnt <= (clear || tick) ? '0 : cnt + 1'b1;

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8-bit asynchronous serial transmitter with optional parity and 1/2 stop bits
//   clk, reset (async, active-high);
//   tx_en/tx_data: start request and byte, taken only in IDLE;
//   tx: serial line (idles high); tx_done: one-cycle end-of-frame pulse;
//   busy: high from acceptance through the tx_done cycle.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_en,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       tx_done,
    output logic       busy
);

    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

    state_t     state, state_n;
    logic [7:0] shift, shift_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic       par, par_n;
    logic       tick, clear, tx_n;

    baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk  (clk),
        .reset(reset),
        .clear(clear),
        .tick (tick)
    );

    // bit_cnt counts data bits, wraps to 0 after bit 7, then counts stop bits
    always_comb begin
        state_n   = state;
        shift_n   = shift;
        bit_cnt_n = bit_cnt;
        par_n     = par;
        clear     = 1'b0;
        case (state)
            ST_IDLE: if (tx_en) begin
                state_n   = ST_START;
                shift_n   = tx_data;
                bit_cnt_n = '0;
                par_n     = 1'b0;
                clear     = 1'b1;
            end
            ST_START: if (tick) state_n = ST_DATA;
            ST_DATA: if (tick) begin
                shift_n   = shift >> 1;
                par_n     = par ^ shift[0];
                bit_cnt_n = bit_cnt + 1'b1;
                if (bit_cnt == 3'd7) state_n = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: if (tick) state_n = ST_STOP;
            ST_STOP: if (tick) begin
                bit_cnt_n = bit_cnt + 1'b1;
                if (bit_cnt == STOP_LAST) state_n = ST_DONE;
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
        // outputs are registered from next-state values so they line up with the state
        tx_n = state_n == ST_START  ? 1'b0 :
               state_n == ST_DATA   ? shift_n[0] :
               state_n == ST_PARITY ? par_n ^ (PARITY == PAR_ODD) : 1'b1;
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state   <= ST_IDLE;
            shift   <= '0;
            bit_cnt <= '0;
            par     <= 1'b0;
            tx      <= 1'b1;
            tx_done <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            shift   <= shift_n;
            bit_cnt <= bit_cnt_n;
            par     <= par_n;
            tx      <= tx_n;
            tx_done <= state_n == ST_DONE;
            busy    <= state_n != ST_IDLE;
        end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter on the processor's UART output path. It accepts a byte from the load/store unit's `tx_en`/`tx_data` handshake and shifts it out as an 8-bit asynchronous frame on a single line. It pulses `tx_done` back to the load/store unit when the frame is complete. It sits between the processor core and the board's UART TX pin and mirrors the existing receive path that supplies `rx_data`/`rx_done`.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per serial bit; must be ≥ 2.
- `PARITY`, default 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, default 1: 1 or 2.

- `clk` input 1: the single clock; all state changes on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `tx_en` input 1: start request; sampled only in IDLE.
- `tx_data` input 8: byte to send; captured on the accepting edge.
- `tx` output 1: serial line; idles high.
- `tx_done` output 1: one-cycle pulse at the end of each frame.
- `busy` output 1: high from the accepting edge until the cycle after the `tx_done` pulse.

## Operation
- Reset values: `tx`=1, `tx_done`=0, `busy`=0, state=IDLE, all counters 0, shift register 0. Reset takes effect immediately (asynchronous), including mid-frame; any partial frame is abandoned and `tx` returns high.
- States: IDLE → START → DATA → PARITY (only if `PARITY`≠0) → STOP → DONE → IDLE.
- IDLE: `tx`=1. On an edge with `tx_en`=1, latch `tx_data` into the shift register, clear the bit counter and parity accumulator, and go to START.
- START: `tx`=0 for `CLKS_PER_BIT` cycles.
- DATA: 8 bits, LSB first, each held `CLKS_PER_BIT` cycles. Shift right at each bit boundary. Accumulate the XOR of the data bits.
- PARITY: send the XOR for even parity, or its inverse for odd parity, for `CLKS_PER_BIT` cycles.
- STOP: `tx`=1 for `STOP_BITS`×`CLKS_PER_BIT` cycles.
- DONE: exactly one cycle; `tx`=1, `tx_done`=1, `busy`=1. Then go to IDLE.
- `tx_en` outside IDLE (including DONE) is ignored: not queued, and `tx_data` is not sampled.
- The baud counter is 0 to `CLKS_PER_BIT`−1. Width is `$clog2(CLKS_PER_BIT)`. It wraps to 0 at the terminal count and advances the bit/state at that point. The bit counter is 3 bits.

## Timing
- `tx`, `tx_done` and `busy` are registered. There is no combinational path from inputs to outputs.
- Let E0 be the accepting edge. `tx` goes low and `busy` goes high in the cycle after E0.
- Frame length N bits = 1 + 8 + (`PARITY`≠0) + `STOP_BITS`.
- `tx_done` is high in the cycle starting at E0 + N×`CLKS_PER_BIT`.
- IDLE is re-entered one cycle later, so the next `tx_en` can be accepted at E0 + N×`CLKS_PER_BIT` + 1.
- Minimum frame-to-frame period is N×`CLKS_PER_BIT` + 2 cycles, with line high between frames.
- `tx_en` held high continuously produces back-to-back frames at that period.

## Structure
- Shared package `uart_pkg` holds:
  - the state encoding (IDLE, START, DATA, PARITY, STOP, DONE; 3 bits);
  - parity-mode constants PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2.
- The receive side reuses the same package.
- One sub-module, `baud_counter`: parameter `CLKS_PER_BIT`; inputs `clk`, `reset`, `clear`; output `tick`, pulsed on the terminal count. The FSM clears it on acceptance and consumes `tick`.

## Test plan
Bench uses `CLKS_PER_BIT`=4.
- **Basic frame, 0xA5.** Defaults otherwise, `tx_en` pulsed at E0 with `tx_data`=0xA5. `tx` samples at mid-bit are 0,1,0,1,0,0,1,0,1,1. `tx_done` is high for exactly one cycle at E0+40. `busy` falls the next cycle.
- **Parity.** 0xA5 (four ones) sends parity bit 0 with `PARITY`=1 and 1 with `PARITY`=2. 0x07 with `PARITY`=1 sends 1. `tx_done` is at E0+44.
- **Two stop bits.** `STOP_BITS`=2, 0x00 sent. `tx` is low for 36 cycles, then high for 8 cycles. `tx_done` is at E0+44.
- **Busy/ignore.** Pulse `tx_en` with 0x3C, then pulse `tx_en` with 0xFF at E0+10 and again in the DONE cycle. Only the 0x3C frame appears and only one `tx_done` pulse occurs.
- **Back-to-back.** Hold `tx_en` high with 0x55. Frames start 42 cycles apart, with `tx` high during the gap cycles.
- **Reset mid-frame.** Assert `reset` at E0+17, during DATA. `tx`=1, `busy`=0 and `tx_done`=0 immediately, before the next edge. After release, a new 0x81 frame transmits correctly.
